shot_controller: RTL and testbench
==================================

// Module: shot_controller
// PURPOSE
//  Initiator side of the matrix memory access port: turns one player shot (x,y) into a single
//  read-modify-write on the board memory and classifies the result as miss, hit, repeat or invalid.
//  Sits between player/input logic and one matrix memory input port; the in_sel arbiter is external.
//  Also tracks shots fired and latches game-over when the board reports no submarine bits left.
// PARAMETERS
//  WIDTH    6   board side; legal coordinates are 0..WIDTH-1
//  TIMEOUT  8   max cycles in WAIT for mem_data_out_valid before abort (>=2)
//  CNT_W    8   width of shot_count
// PORTS
//  clk                 in   1      clock, rising edge
//  rstn                in   1      asynchronous active-low reset
//  shot_valid          in   1      shot request present
//  shot_ready          out  1      controller accepts shot (IDLE only)
//  shot_x              in   3      row of shot
//  shot_y              in   3      column of shot
//  mem_x               out  3      memory row
//  mem_y               out  3      memory column
//  mem_wr_en           out  1      memory write enable
//  mem_data_in         out  2      memory write data
//  mem_data_in_valid   out  1      memory request strobe
//  mem_data_out        in   2      old cell value returned by memory
//  mem_data_out_valid  in   1      memory response strobe
//  mem_empty           in   1      memory reports all bit0 clear
//  res_valid           out  1      one-cycle result strobe
//  res_code            out  2      00 miss, 01 hit, 10 repeat, 11 invalid/timeout
//  shot_count          out  CNT_W  accepted legal shots, saturating
//  game_over           out  1      sticky: last submarine cell destroyed
// BEHAVIOUR
//  Cell encoding: bit0 = submarine present, bit1 = already shot. Shot writes 2'b10.
//  Reset: all outputs 0; state IDLE; shot_ready 0 during reset, 1 in first IDLE cycle after release.
//  States: IDLE, ISSUE, WAIT, REPORT, OVER.
//  IDLE: shot_ready=1; on shot_valid latch x,y.
//    x>=WIDTH or y>=WIDTH -> REPORT with code 11; no memory access; shot_count unchanged.
//    Otherwise -> ISSUE.
//  ISSUE: one cycle only: mem_data_in_valid=1, mem_wr_en=1, mem_data_in=2'b10, mem_x/mem_y=latched.
//    Then -> WAIT with timer cleared. shot_count +1, saturating at all-ones.
//  WAIT: mem_data_in_valid=0, mem_wr_en=0. Memory response is nominally 1 cycle later.
//    On mem_data_out_valid, classify the old value:
//      1x -> repeat (10), 01 -> hit (01), 00 -> miss (00).
//    If the timer reaches TIMEOUT first -> code 11.
//    Either way -> REPORT.
//  REPORT: res_valid=1 for exactly one cycle with res_code held.
//    If code=hit and mem_empty=1 in this cycle -> game_over<=1 and next state OVER.
//    Otherwise -> IDLE.
//    mem_empty is sampled in REPORT, not WAIT, so the write has fully committed.
//  OVER: shot_ready=0; shot_valid ignored; game_over stays 1 until reset.
//  Latency: legal shot accept edge -> res_valid = 3 cycles with a 1-cycle memory.
//    Invalid shot -> res_valid = 1 cycle.
//  shot_ready is low in ISSUE/WAIT/REPORT; at most one shot in flight.
//  Stray mem_data_out_valid in IDLE/ISSUE/REPORT/OVER: ignored.
//  mem_x/mem_y/mem_data_in hold their last values outside ISSUE; only the strobes return to 0.
//  Reset mid-operation (any state) -> IDLE, outputs cleared, game_over and shot_count cleared.
// TESTING
//  1. Reset, shot (0,0) on a cell holding 01 -> one ISSUE strobe with wr_en=1, data 10;
//     res_valid 3 cycles after accept, res_code=01, shot_count=1.
//  2. Same (0,0) again -> res_code=10 (repeat); shot_count=2; cell value stays 10.
//  3. Shot (6,2) -> no mem_data_in_valid; res_code=11 next cycle; shot_count unchanged.
//  4. Memory response withheld -> res_code=11 after TIMEOUT=8 WAIT cycles; back to IDLE.
//  5. Hit on the last submarine cell with mem_empty=1 -> res_code=01, game_over=1;
//     further shot_valid ignored, shot_ready=0.
//  6. rstn low during WAIT -> all outputs 0; first shot after release behaves as in scenario 1.

Source files
------------

// File: rtl/shot_controller.sv
// shot_controller
//   Initiator side of one matrix-memory input port. Turns a player shot (x,y)
//   into a single read-modify-write of the board memory, then classifies the
//   old cell value as miss / hit / repeat, or reports invalid / timeout.
//   It also counts accepted legal shots and latches game-over once the last
//   submarine cell has been destroyed.
//
//   Cell encoding: bit0 = submarine present, bit1 = already shot.
//   A shot always writes 2'b10.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   shot_valid/ready     shot handshake; ready only while idle
//   shot_x, shot_y       shot coordinates
//   mem_x, mem_y         memory cell address (held between requests)
//   mem_wr_en            memory write enable
//   mem_data_in          memory write data (held between requests)
//   mem_data_in_valid    memory request strobe
//   mem_data_out         old cell value returned by memory
//   mem_data_out_valid   memory response strobe
//   mem_empty            memory reports no submarine bits left
//   res_valid            one-cycle result strobe
//   res_code             00 miss, 01 hit, 10 repeat, 11 invalid/timeout
//   shot_count           accepted legal shots, saturating
//   game_over            sticky until reset
module shot_controller #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shot_valid,
    output logic             shot_ready,
    input  logic [2:0]       shot_x,
    input  logic [2:0]       shot_y,
    output logic [2:0]       mem_x,
    output logic [2:0]       mem_y,
    output logic             mem_wr_en,
    output logic [1:0]       mem_data_in,
    output logic             mem_data_in_valid,
    input  logic [1:0]       mem_data_out,
    input  logic             mem_data_out_valid,
    input  logic             mem_empty,
    output logic             res_valid,
    output logic [1:0]       res_code,
    output logic [CNT_W-1:0] shot_count,
    output logic             game_over
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_MISS    = 2'b00;
    localparam logic [1:0] CODE_HIT     = 2'b01;
    localparam logic [1:0] CODE_REPEAT  = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REPORT,
        S_OVER
    } state_t;

    state_t             state_q,       state_d;
    logic [2:0]         mem_x_q,       mem_x_d;
    logic [2:0]         mem_y_q,       mem_y_d;
    logic [1:0]         mem_data_in_q, mem_data_in_d;
    logic [TMR_W-1:0]   timer_q,       timer_d;
    logic [1:0]         code_q,        code_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic               game_over_q,   game_over_d;
    logic               shot_legal;

    assign shot_legal = ({29'b0, shot_x} < 32'(WIDTH)) &&
                        ({29'b0, shot_y} < 32'(WIDTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            mem_x_q       <= '0;
            mem_y_q       <= '0;
            mem_data_in_q <= '0;
            timer_q       <= '0;
            code_q        <= '0;
            count_q       <= '0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_x_q       <= mem_x_d;
            mem_y_q       <= mem_y_d;
            mem_data_in_q <= mem_data_in_d;
            timer_q       <= timer_d;
            code_q        <= code_d;
            count_q       <= count_d;
            game_over_q   <= game_over_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_x_d       = mem_x_q;
        mem_y_d       = mem_y_q;
        mem_data_in_d = mem_data_in_q;
        timer_d       = timer_q;
        code_d        = code_q;
        count_d       = count_q;
        game_over_d   = game_over_q;

        case (state_q)
            S_IDLE: begin
                if (shot_valid) begin
                    if (!shot_legal) begin
                        code_d  = CODE_INVALID;
                        state_d = S_REPORT;
                    end else begin
                        // Address registers only move for legal shots, so
                        // they keep the last real request otherwise.
                        mem_x_d       = shot_x;
                        mem_y_d       = shot_y;
                        mem_data_in_d = 2'b10;
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_data_out_valid) begin
                    if (mem_data_out[1]) begin
                        code_d = CODE_REPEAT;
                    end else if (mem_data_out[0]) begin
                        code_d = CODE_HIT;
                    end else begin
                        code_d = CODE_MISS;
                    end
                    state_d = S_REPORT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent waiting.
                    code_d  = CODE_INVALID;
                    state_d = S_REPORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_REPORT: begin
                // mem_empty is looked at here rather than in WAIT so the
                // shot's own write is already reflected in it.
                if (code_q == CODE_HIT && mem_empty) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gating with rstn keeps ready low while reset is held even though the
    // state register already sits in IDLE.
    assign shot_ready        = (state_q == S_IDLE) && rstn;
    assign mem_data_in_valid = (state_q == S_ISSUE);
    assign mem_wr_en         = (state_q == S_ISSUE);
    assign mem_x             = mem_x_q;
    assign mem_y             = mem_y_q;
    assign mem_data_in       = mem_data_in_q;
    assign res_valid         = (state_q == S_REPORT);
    assign res_code          = code_q;
    assign shot_count        = count_q;
    assign game_over         = game_over_q;

endmodule

// File: tb/tb_shot_controller.sv
// tb_shot_controller
//   Directed bench for shot_controller. A small behavioural board memory
//   answers requests one cycle later with the old cell value and commits the
//   write; its response can be withheld to provoke a timeout.
module tb_shot_controller;

    logic       clk;
    logic       rstn;
    logic       shot_valid;
    logic       shot_ready;
    logic [2:0] shot_x;
    logic [2:0] shot_y;
    logic [2:0] mem_x;
    logic [2:0] mem_y;
    logic       mem_wr_en;
    logic [1:0] mem_data_in;
    logic       mem_data_in_valid;
    logic [1:0] mem_data_out;
    logic       mem_data_out_valid;
    logic       mem_empty;
    logic       res_valid;
    logic [1:0] res_code;
    logic [7:0] shot_count;
    logic       game_over;

    // Board model and its controls
    logic [1:0] board [0:7][0:7];
    logic       board_clear;
    logic       preset_en;
    logic [2:0] preset_x;
    logic [2:0] preset_y;
    logic [1:0] preset_val;
    logic       withhold;
    int         req_count;
    logic       last_wr;
    logic [1:0] last_data;

    int total_checks;
    int passed_checks;
    int fail_checks;

    shot_controller #(.WIDTH(6), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .shot_valid         (shot_valid),
        .shot_ready         (shot_ready),
        .shot_x             (shot_x),
        .shot_y             (shot_y),
        .mem_x              (mem_x),
        .mem_y              (mem_y),
        .mem_wr_en          (mem_wr_en),
        .mem_data_in        (mem_data_in),
        .mem_data_in_valid  (mem_data_in_valid),
        .mem_data_out       (mem_data_out),
        .mem_data_out_valid (mem_data_out_valid),
        .mem_empty          (mem_empty),
        .res_valid          (res_valid),
        .res_code           (res_code),
        .shot_count         (shot_count),
        .game_over          (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read of the old value plus write commit.
    always @(posedge clk) begin
        mem_data_out_valid <= 1'b0;
        if (board_clear) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    board[i][j] <= 2'b00;
        end else if (preset_en) begin
            board[preset_x][preset_y] <= preset_val;
        end
        if (mem_data_in_valid) begin
            req_count <= req_count + 1;
            last_wr   <= mem_wr_en;
            last_data <= mem_data_in;
            if (!withhold) begin
                mem_data_out       <= board[mem_x][mem_y];
                mem_data_out_valid <= 1'b1;
            end
            if (mem_wr_en) board[mem_x][mem_y] <= mem_data_in;
        end
    end

    always_comb begin
        mem_empty = 1'b1;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (board[i][j][0]) mem_empty = 1'b0;
    end

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            fail_checks++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preset_cell(input logic [2:0] x, input logic [2:0] y,
                               input logic [1:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_x   = x;
        preset_y   = y;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Present one shot, wait (bounded) for the result strobe, and check the
    // accept-to-result latency, the code, and that the strobe lasts one cycle.
    task automatic apply_stimulus(input string tag, input logic [2:0] x,
                                  input logic [2:0] y, input logic [1:0] exp_code,
                                  input int exp_lat);
        int n;
        @(negedge clk);
        shot_valid = 1'b1;
        shot_x     = x;
        shot_y     = y;
        @(posedge clk);
        #1;
        shot_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        check_output({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_output({tag, "_code"}, 32'(res_code), 32'(exp_code));
        @(posedge clk);
        #1;
        check_output({tag, "_strobe_len"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        int req_before;
        total_checks  = 0;
        passed_checks = 0;
        fail_checks   = 0;
        rstn          = 1'b0;
        shot_valid    = 1'b0;
        shot_x        = 3'd0;
        shot_y        = 3'd0;
        board_clear   = 1'b1;
        preset_en     = 1'b0;
        preset_x      = 3'd0;
        preset_y      = 3'd0;
        preset_val    = 2'b00;
        withhold      = 1'b0;
        req_count     = 0;
        last_wr       = 1'b0;
        last_data     = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        board_clear = 1'b0;
        check_output("rst_ready", 32'(shot_ready), 32'd0);
        check_output("rst_res_valid", 32'(res_valid), 32'd0);
        check_output("rst_req", 32'(mem_data_in_valid), 32'd0);
        check_output("rst_count", 32'(shot_count), 32'd0);
        check_output("rst_game_over", 32'(game_over), 32'd0);
        preset_cell(3'd0, 3'd0, 2'b01);
        preset_cell(3'd3, 3'd4, 2'b01);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_output("post_rst_ready", 32'(shot_ready), 32'd1);

        // 1: hit on (0,0)
        req_before = req_count;
        apply_stimulus("s1", 3'd0, 3'd0, 2'b01, 3);
        check_output("s1_req_count", 32'(req_count - req_before), 32'd1);
        check_output("s1_wr_en", 32'(last_wr), 32'd1);
        check_output("s1_wr_data", 32'(last_data), 32'h2);
        check_output("s1_shot_count", 32'(shot_count), 32'd1);
        check_output("s1_ready", 32'(shot_ready), 32'd1);

        // 2: repeat on (0,0)
        apply_stimulus("s2", 3'd0, 3'd0, 2'b10, 3);
        check_output("s2_shot_count", 32'(shot_count), 32'd2);
        check_output("s2_cell", 32'(board[0][0]), 32'h2);

        // 3: out-of-range row
        req_before = req_count;
        apply_stimulus("s3", 3'd6, 3'd2, 2'b11, 1);
        check_output("s3_req_count", 32'(req_count - req_before), 32'd0);
        check_output("s3_shot_count", 32'(shot_count), 32'd2);

        // 4: memory never answers -> 8 WAIT cycles then timeout
        withhold = 1'b1;
        apply_stimulus("s4", 3'd1, 3'd1, 2'b11, 10);
        withhold = 1'b0;
        check_output("s4_shot_count", 32'(shot_count), 32'd3);
        check_output("s4_ready", 32'(shot_ready), 32'd1);

        // Miss, then an invalid column: address outputs keep the miss's cell
        apply_stimulus("miss", 3'd2, 3'd5, 2'b00, 3);
        check_output("miss_shot_count", 32'(shot_count), 32'd4);
        apply_stimulus("inv_y", 3'd1, 3'd7, 2'b11, 1);
        check_output("hold_mem_x", 32'(mem_x), 32'd2);
        check_output("hold_mem_y", 32'(mem_y), 32'd5);
        check_output("hold_data", 32'(mem_data_in), 32'h2);
        check_output("inv_y_shot_count", 32'(shot_count), 32'd4);

        // 5: last submarine cell -> game over, further shots ignored
        apply_stimulus("s5", 3'd3, 3'd4, 2'b01, 3);
        check_output("s5_game_over", 32'(game_over), 32'd1);
        check_output("s5_ready", 32'(shot_ready), 32'd0);
        check_output("s5_shot_count", 32'(shot_count), 32'd5);
        req_before = req_count;
        @(negedge clk);
        shot_valid = 1'b1;
        shot_x     = 3'd1;
        shot_y     = 3'd2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_output("over_res_valid", 32'(res_valid), 32'd0);
            check_output("over_ready", 32'(shot_ready), 32'd0);
        end
        shot_valid = 1'b0;
        check_output("over_req_count", 32'(req_count - req_before), 32'd0);
        check_output("over_game_over", 32'(game_over), 32'd1);

        // 6: reset while waiting on memory
        rstn = 1'b0;
        #1;
        check_output("r6_game_over", 32'(game_over), 32'd0);
        rstn = 1'b1;
        preset_cell(3'd0, 3'd0, 2'b01);
        preset_cell(3'd5, 3'd5, 2'b01);
        @(negedge clk);
        shot_valid = 1'b1;
        shot_x     = 3'd4;
        shot_y     = 3'd4;
        @(posedge clk);
        #1;
        shot_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("r6_in_wait_req", 32'(mem_data_in_valid), 32'd0);
        check_output("r6_in_wait_ready", 32'(shot_ready), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check_output("r6_ready", 32'(shot_ready), 32'd0);
        check_output("r6_res_valid", 32'(res_valid), 32'd0);
        check_output("r6_code", 32'(res_code), 32'd0);
        check_output("r6_count", 32'(shot_count), 32'd0);
        check_output("r6_mem_x", 32'(mem_x), 32'd0);
        check_output("r6_data", 32'(mem_data_in), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        req_before = req_count;
        apply_stimulus("r6_s1", 3'd0, 3'd0, 2'b01, 3);
        check_output("r6_s1_req_count", 32'(req_count - req_before), 32'd1);
        check_output("r6_s1_shot_count", 32'(shot_count), 32'd1);
        check_output("r6_s1_game_over", 32'(game_over), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
